cc_digit_scanner: RTL and testbench

- Parametrised, time-multiplexed digit-select sequencer for the multi-digit 7-segment display path.
- Replaces the fixed 3-bit-to-4-bit combinational select decoder with an N-digit scanner. The scanner has a prescaled dwell time per digit, anti-ghosting dead-time, a run-time active-digit count, a per-digit blank mask and selectable output polarity.
- Output drives digit enables/anodes directly.
- Index and strobe outputs steer the segment-data mux upstream.

---
 rtl/cc_digit_scanner.sv | 136 +++++++++++++
 tb/tb_cc_digit_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cc_digit_scanner.sv
// N-digit time-multiplexed digit-select scanner with per-slot dead-time,
// run-time digit count, per-digit blank mask and selectable output polarity.
module cc_digit_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int PRESCALE       = 50000,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLANK_CYCLES   = 500,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                  CC_DIGIT_SCANNER_CLOCK_50,
  input  logic                  CC_DIGIT_SCANNER_RESET_InHigh,
  input  logic                  CC_DIGIT_SCANNER_enable_In,
  input  logic [SEL_WIDTH:0]    CC_DIGIT_SCANNER_activeDigits_InBUS,
  input  logic [NUM_DIGITS-1:0] CC_DIGIT_SCANNER_blankMask_InBUS,
  output logic [NUM_DIGITS-1:0] CC_DIGIT_SCANNER_select_OutBUS,
  output logic [SEL_WIDTH-1:0]  CC_DIGIT_SCANNER_index_OutBUS,
  output logic                  CC_DIGIT_SCANNER_strobe_Out
);

  localparam int CW = SEL_WIDTH + 1;
  localparam bit C_NO_BLANK = (BLANK_CYCLES == 0);
  localparam logic [PRESCALE_WIDTH-1:0] C_SLOT_LAST  = PRESCALE_WIDTH'(PRESCALE - 1);
  localparam logic [PRESCALE_WIDTH-1:0] C_BLANK_LAST =
    PRESCALE_WIDTH'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [NUM_DIGITS-1:0] C_SEL_IDLE =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [SEL_WIDTH-1:0]      r_index;
  logic                      r_strobe;
  logic [NUM_DIGITS-1:0]     r_select;

  logic [CW-1:0]         w_n_eff;
  logic [CW-1:0]         w_index_ext;
  logic                  w_last;
  logic [SEL_WIDTH-1:0]  w_index_next;
  logic                  w_cur_ok;
  logic                  w_next_ok;
  logic [NUM_DIGITS-1:0] w_hit_cur;
  logic [NUM_DIGITS-1:0] w_hit_next;
  logic [NUM_DIGITS-1:0] w_sel_cur;
  logic [NUM_DIGITS-1:0] w_sel_next;

  // Clamp the requested digit count into 1..NUM_DIGITS.
  assign w_n_eff = (CC_DIGIT_SCANNER_activeDigits_InBUS == '0) ? CW'(1) :
                   (CC_DIGIT_SCANNER_activeDigits_InBUS > CW'(NUM_DIGITS)) ? CW'(NUM_DIGITS) :
                   CC_DIGIT_SCANNER_activeDigits_InBUS;

  assign w_index_ext  = {1'b0, r_index};
  assign w_last       = (w_index_ext + CW'(1)) >= w_n_eff;
  assign w_index_next = w_last ? '0 : r_index + 1'b1;
  assign w_cur_ok     = w_index_ext < w_n_eff;
  assign w_next_ok    = {1'b0, w_index_next} < w_n_eff;

  // Active-high one-hot patterns for the current index and the index after slot end.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hit
    assign w_hit_cur[gi]  = w_cur_ok && (r_index == SEL_WIDTH'(gi)) &&
                            !CC_DIGIT_SCANNER_blankMask_InBUS[gi];
    assign w_hit_next[gi] = w_next_ok && (w_index_next == SEL_WIDTH'(gi)) &&
                            !CC_DIGIT_SCANNER_blankMask_InBUS[gi];
  end

  assign w_sel_cur  = (ACTIVE_LOW != 0) ? ~w_hit_cur  : w_hit_cur;
  assign w_sel_next = (ACTIVE_LOW != 0) ? ~w_hit_next : w_hit_next;

  always_ff @(posedge CC_DIGIT_SCANNER_CLOCK_50) begin
    if (CC_DIGIT_SCANNER_RESET_InHigh) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_index  <= '0;
      r_strobe <= 1'b0;
      r_select <= C_SEL_IDLE;
    end else begin
      r_strobe <= 1'b0;
      if (!CC_DIGIT_SCANNER_enable_In) begin
        // Disable wins over slot end: index is retained and no strobe is issued.
        r_state  <= ST_IDLE;
        r_presc  <= '0;
        r_select <= C_SEL_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_presc <= '0;
            if (C_NO_BLANK) begin
              r_state  <= ST_DRIVE;
              r_select <= w_sel_cur;
            end else begin
              r_state  <= ST_BLANK;
              r_select <= C_SEL_IDLE;
            end
          end
          ST_BLANK: begin
            r_presc <= r_presc + 1'b1;
            if (r_presc == C_BLANK_LAST) begin
              r_state  <= ST_DRIVE;
              r_select <= w_sel_cur;
            end else begin
              r_select <= C_SEL_IDLE;
            end
          end
          ST_DRIVE: begin
            if (r_presc == C_SLOT_LAST) begin
              r_presc  <= '0;
              r_strobe <= 1'b1;
              r_index  <= w_index_next;
              if (C_NO_BLANK) begin
                r_state  <= ST_DRIVE;
                r_select <= w_sel_next;
              end else begin
                r_state  <= ST_BLANK;
                r_select <= C_SEL_IDLE;
              end
            end else begin
              r_presc  <= r_presc + 1'b1;
              r_select <= w_sel_cur;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_select <= C_SEL_IDLE;
          end
        endcase
      end
    end
  end

  assign CC_DIGIT_SCANNER_select_OutBUS = r_select;
  assign CC_DIGIT_SCANNER_index_OutBUS  = r_index;
  assign CC_DIGIT_SCANNER_strobe_Out    = r_strobe;

endmodule

// File: tb/tb_cc_digit_scanner.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, per-DUT
// monitors pop and compare on the falling edge.
module tb_cc_digit_scanner;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       stb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       en = 1'b0;
  logic [2:0] ad = 3'd4;
  logic [3:0] mask = 4'b0000;

  logic [3:0] sel_a, sel_b;
  logic [1:0] idx_a, idx_b;
  logic       stb_a, stb_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_a = 0;
  int   txn_b = 0;

  always #5 clk = ~clk;

  cc_digit_scanner #(
    .NUM_DIGITS(4), .SEL_WIDTH(2), .PRESCALE(4), .PRESCALE_WIDTH(4),
    .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut_a (
    .CC_DIGIT_SCANNER_CLOCK_50          (clk),
    .CC_DIGIT_SCANNER_RESET_InHigh      (rst_a),
    .CC_DIGIT_SCANNER_enable_In         (en),
    .CC_DIGIT_SCANNER_activeDigits_InBUS(ad),
    .CC_DIGIT_SCANNER_blankMask_InBUS   (mask),
    .CC_DIGIT_SCANNER_select_OutBUS     (sel_a),
    .CC_DIGIT_SCANNER_index_OutBUS      (idx_a),
    .CC_DIGIT_SCANNER_strobe_Out        (stb_a)
  );

  cc_digit_scanner #(
    .NUM_DIGITS(4), .SEL_WIDTH(2), .PRESCALE(4), .PRESCALE_WIDTH(4),
    .BLANK_CYCLES(0), .ACTIVE_LOW(0)
  ) dut_b (
    .CC_DIGIT_SCANNER_CLOCK_50          (clk),
    .CC_DIGIT_SCANNER_RESET_InHigh      (rst_b),
    .CC_DIGIT_SCANNER_enable_In         (en),
    .CC_DIGIT_SCANNER_activeDigits_InBUS(ad),
    .CC_DIGIT_SCANNER_blankMask_InBUS   (mask),
    .CC_DIGIT_SCANNER_select_OutBUS     (sel_b),
    .CC_DIGIT_SCANNER_index_OutBUS      (idx_b),
    .CC_DIGIT_SCANNER_strobe_Out        (stb_b)
  );

  // One clock edge on DUT A, then record what it must show afterwards.
  task automatic step_a(input logic [3:0] s, input logic [1:0] i, input logic b);
    @(posedge clk);
    #1;
    qa.push_back('{sel: s, idx: i, stb: b});
  endtask

  task automatic step_b(input logic [3:0] s, input logic [1:0] i, input logic b);
    @(posedge clk);
    #1;
    qb.push_back('{sel: s, idx: i, stb: b});
  endtask

  // One 4-cycle slot on DUT A: a dead-time cycle then three driven cycles.
  task automatic slot_a(input logic [1:0] d, input logic [3:0] drv, input logic b);
    step_a(4'b1111, d, b);
    for (int k = 0; k < 3; k++) step_a(drv, d, 1'b0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      checks++;
      txn_a++;
      if ({sel_a, idx_a, stb_a} !== e) begin
        errors++;
        $display("FAIL dutA txn %0d: got sel=%b idx=%0d stb=%b, want sel=%b idx=%0d stb=%b",
                 txn_a, sel_a, idx_a, stb_a, e.sel, e.idx, e.stb);
      end else begin
        $display("txn A %0d sel=%b idx=%0d stb=%b ok", txn_a, sel_a, idx_a, stb_a);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      checks++;
      txn_b++;
      if ({sel_b, idx_b, stb_b} !== e) begin
        errors++;
        $display("FAIL dutB txn %0d: got sel=%b idx=%0d stb=%b, want sel=%b idx=%0d stb=%b",
                 txn_b, sel_b, idx_b, stb_b, e.sel, e.idx, e.stb);
      end else begin
        $display("txn B %0d sel=%b idx=%0d stb=%b ok", txn_b, sel_b, idx_b, stb_b);
      end
    end
  end

  initial begin
    // Reset held three cycles, then idle with enable low.
    for (int k = 0; k < 3; k++) step_a(4'b1111, 2'd0, 1'b0);
    rst_a = 1'b0;
    for (int k = 0; k < 2; k++) step_a(4'b1111, 2'd0, 1'b0);

    // Full 4-digit scan, wrapping back to digit 0.
    en = 1'b1;
    slot_a(2'd0, 4'b1110, 1'b0);
    slot_a(2'd1, 4'b1101, 1'b1);
    slot_a(2'd2, 4'b1011, 1'b1);
    slot_a(2'd3, 4'b0111, 1'b1);
    slot_a(2'd0, 4'b1110, 1'b1);

    // Two digits only: index alternates 1,0,1,0.
    ad = 3'd2;
    slot_a(2'd1, 4'b1101, 1'b1);
    slot_a(2'd0, 4'b1110, 1'b1);
    slot_a(2'd1, 4'b1101, 1'b1);
    slot_a(2'd0, 4'b1110, 1'b1);

    // Zero requested digits behaves as one digit.
    ad = 3'd0;
    slot_a(2'd0, 4'b1110, 1'b1);
    slot_a(2'd0, 4'b1110, 1'b1);

    // Oversized count clamps to 4; digit 1 masked but its slot still consumed.
    ad = 3'd7;
    mask = 4'b0010;
    slot_a(2'd1, 4'b1111, 1'b1);
    step_a(4'b1111, 2'd2, 1'b1);
    step_a(4'b1011, 2'd2, 1'b0);

    // Drop enable mid-drive of digit 2, then resume with dead-time first.
    en = 1'b0;
    step_a(4'b1111, 2'd2, 1'b0);
    step_a(4'b1111, 2'd2, 1'b0);
    en = 1'b1;
    slot_a(2'd2, 4'b1011, 1'b0);
    step_a(4'b1111, 2'd3, 1'b1);
    step_a(4'b0111, 2'd3, 1'b0);

    // Reset mid-drive of digit 3 overrides enable.
    rst_a = 1'b1;
    step_a(4'b1111, 2'd0, 1'b0);
    en = 1'b0;
    rst_a = 1'b0;
    step_a(4'b1111, 2'd0, 1'b0);

    // Active-high, no dead-time variant: contiguous 4-cycle slots.
    rst_a = 1'b1;
    ad = 3'd4;
    mask = 4'b0000;
    step_b(4'b0000, 2'd0, 1'b0);
    rst_b = 1'b0;
    en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      logic [1:0] d;
      logic [3:0] oh;
      d = 2'(s % 4);
      oh = 4'b0001 << d;
      step_b(oh, d, (s > 0));
      for (int k = 0; k < 3; k++) step_b(oh, d, 1'b0);
    end

    // Drain both scoreboards within a bounded number of cycles.
    for (int k = 0; k < 10 && (qa.size() + qb.size()) > 0; k++) @(negedge clk);
    @(negedge clk);
    if ((qa.size() + qb.size()) > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
